fifo_reader: RTL and testbench

Read-side engine for the synchronous FIFO. It drains words through the FIFO's pop/pndng port and presents them downstream as a valid/ready stream. A 3-entry skid buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per clock with no combinational path from `out_ready` to `fifo_pop`. It sits between the FIFO output and any consumer: serializer, bus master or checker.

---
 rtl/fifo_reader.sv | 98 +++++++++
 tb/tb_fifo_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side engine for the synchronous FIFO.
// Pops words through the FIFO pop/pndng port and presents them as a
// valid/ready stream. A 3-entry skid buffer covers the FIFO's one-cycle read
// latency, so one word per clock is sustained while fifo_pop depends only on
// registered state and fifo_pndng (never on out_ready).
module fifo_reader #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_pndng,
    output logic             fifo_pop,
    input  logic [BITS-1:0]  fifo_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  out_data,
    output logic [CNT_W-1:0] words_out,
    output logic             idle
);

    typedef enum logic [1:0] {
        EMPTY,
        PART,
        FULL
    } occ_state_e;

    occ_state_e state_q, state_d;

    logic [BITS-1:0]  mem_q [3];
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             fire;
    logic [2:0]       occ_sum;

    // Pointers count 0,1,2,0 over the three buffer slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop rule, handshake, pointer/occupancy/counter next-state and FSM decode.
    always_comb begin
        out_valid  = (state_q != EMPTY);
        fire       = out_valid && out_ready;
        fifo_pop   = fifo_pndng && !rst && ((3'(occ_q) + 3'(inflight_q)) <= 3'd2);
        inflight_d = fifo_pop;
        occ_sum    = 3'(occ_q) + 3'(inflight_q) - 3'(fire);
        occ_d      = occ_sum[1:0];
        rd_ptr_d   = fire       ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = inflight_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        words_d    = words_q + CNT_W'(fire);
        case (occ_sum)
            3'd0:    state_d = EMPTY;
            3'd3:    state_d = FULL;
            default: state_d = PART;
        endcase
        out_data   = mem_q[rd_ptr_q];
        words_out  = words_q;
        idle       = (state_q == EMPTY) && !inflight_q;
    end

    // Occupancy state register (EMPTY / PART / FULL).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer storage, pointers, in-flight flag and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            assert (occ_sum <= 3'd3);
            if (inflight_q) begin
                mem_q[wr_ptr_q] <= fifo_dout;
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed + random bench for fifo_reader with a behavioural FIFO and a
// scoreboard of popped-but-not-yet-delivered words.
module tb_fifo_reader;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_pndng;
    logic             fifo_pop;
    logic [7:0]       fifo_dout;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [CNT_W-1:0] words_out;
    logic             idle;

    fifo_reader #(.BITS(8), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_pndng (fifo_pndng),
        .fifo_pop   (fifo_pop),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .words_out  (words_out),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo_mem [$];
    logic [7:0] sb [$];
    bit         pndng_en;
    bit         model_on;
    int         exp_cnt;
    int         inflight_m;
    int         delivered;
    int         pops;
    int         fires;
    bit         pop_now;
    bit         fire_now;
    logic [7:0] fire_data;
    logic       prev_valid;
    logic       prev_fire;
    logic       prev_rst;
    logic [7:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        logic [7:0] w;
        logic [7:0] e;
        w = '0;
        fifo_pndng = pndng_en && (fifo_mem.size() != 0);
        #1;
        check("fifo_pop", 32'(fifo_pop), 32'(fifo_pndng && !rst && (sb.size() <= 2)));
        if (model_on) begin
            check("out_valid", 32'(out_valid), 32'((sb.size() - inflight_m) != 0));
            check("idle", 32'(idle), 32'(sb.size() == 0));
            if (prev_valid && !prev_fire && !prev_rst)
                check("hold_data", 32'(out_data), 32'(prev_data));
        end
        pop_now  = fifo_pop;
        fire_now = out_valid && out_ready;
        if (pop_now) pops++;
        if (fire_now) begin
            fires++;
            fire_data = out_data;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL stale_word: observed fire data %0h expected no fire", out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("order_data", 32'(out_data), 32'(e));
                delivered++;
            end
        end
        if (pop_now && fifo_mem.size() != 0) begin
            w = fifo_mem.pop_front();
            sb.push_back(w);
        end
        prev_valid = out_valid;
        prev_data  = out_data;
        prev_fire  = fire_now;
        prev_rst   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            exp_cnt    = 0;
            inflight_m = 0;
            model_on   = 1'b1;
        end else begin
            if (pop_now) fifo_dout = w;
            inflight_m = pop_now ? 1 : 0;
            if (fire_now) exp_cnt++;
        end
        @(negedge clk);
        if (model_on)
            check("words_out", 32'(words_out), 32'(exp_cnt % (1 << CNT_W)));
    endtask

    initial begin
        int d0;
        int pushed;
        rst        = 1'b1;
        out_ready  = 1'b0;
        pndng_en   = 1'b1;
        fifo_pndng = 1'b0;
        fifo_dout  = '0;
        model_on   = 1'b0;
        exp_cnt    = 0;
        inflight_m = 0;
        delivered  = 0;
        pops       = 0;
        fires      = 0;
        prev_valid = 1'b0;
        prev_fire  = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = '0;
        fire_data  = '0;
        @(negedge clk);

        // Reset held two cycles with data pending
        fifo_mem.push_back(8'h77);
        cycle();
        cycle();
        rst = 1'b0;
        fifo_mem.delete();
        fifo_pndng = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_words", 32'(words_out), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        @(negedge clk);

        // Single word: pop at c0, valid at c2
        fifo_mem.push_back(8'hA5);
        out_ready = 1'b1;
        cycle();
        check("single_pop_c0", 32'(pop_now), 32'd1);
        cycle();
        check("single_nofire_c1", 32'(fire_now), 32'd0);
        cycle();
        check("single_fire_c2", 32'(fire_now), 32'd1);
        check("single_data_c2", 32'(fire_data), 32'hA5);
        check("single_idle_c3", 32'(idle), 32'd1);
        check("single_words", 32'(words_out), 32'd1);

        // Streaming 16 words back-to-back; counter wraps 17 -> 1
        for (int i = 1; i <= 16; i++) fifo_mem.push_back(8'(i));
        cycle();
        cycle();
        fires = 0;
        repeat (16) cycle();
        check("stream_consecutive", 32'(fires), 32'd16);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);
        check("stream_words_wrap", 32'(words_out), 32'd1);

        // Backpressure: three pops then stall, head word held
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) fifo_mem.push_back(8'(i));
        pops = 0;
        repeat (10) cycle();
        check("bp_pops", 32'(pops), 32'd3);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        fires = 0;
        repeat (8) cycle();
        check("bp_no_gap", 32'(fires), 32'd8);
        check("bp_drained", 32'(sb.size()), 32'd0);

        // Random ready and FIFO refill over 1000 words
        d0 = delivered;
        pushed = 0;
        for (int c = 0; c < 20000 && (delivered - d0) < 1000; c++) begin
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                fifo_mem.push_back(8'($urandom));
                pushed++;
            end
            pndng_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        pndng_en = 1'b1;
        check("rand_delivered", 32'(delivered - d0), 32'd1000);
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-stream with occ=2 and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) fifo_mem.push_back(8'(8'h31 + 8'(i)));
        repeat (3) cycle();
        check("mid_occ2_valid", 32'(out_valid), 32'd1);
        check("mid_inflight", 32'(inflight_m), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        fifo_mem.delete();
        check("mid_valid0", 32'(out_valid), 32'd0);
        check("mid_idle", 32'(idle), 32'd1);
        check("mid_words0", 32'(words_out), 32'd0);
        out_ready = 1'b1;
        fires = 0;
        repeat (5) cycle();
        check("mid_no_stale", 32'(fires), 32'd0);

        // Counter wrap: 17 words with a 4-bit counter
        d0 = delivered;
        for (int i = 0; i < 17; i++) fifo_mem.push_back(8'(8'h80 + 8'(i)));
        repeat (20) cycle();
        check("wrap_delivered", 32'(delivered - d0), 32'd17);
        check("wrap_words", 32'(words_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
